// File: rtl/arb4way16.sv
// Round-robin arbiter for four 16-bit producers feeding one valid/ready consumer.
// The selected word passes through mux4way16 and is held in an output register.

module mux4way16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       line,
    output logic [WIDTH-1:0] out
);
    always_comb begin
        unique case (line)
            2'b00:   out = a;
            2'b01:   out = b;
            2'b10:   out = c;
            default: out = d;
        endcase
    end
endmodule

module arb4way16 #(
    parameter int WIDTH = 16,
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [WIDTH-1:0] inp3,
    input  logic [WIDTH-1:0] inp4,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       line
);
    localparam logic [3:0] BURST_M1 = 4'(BURST - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic             ptr_valid_q;
    logic [3:0]       burst_cnt_q;
    logic [3:0]       burst_cnt_d;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       line_q;

    logic             cap;
    logic             lock;
    logic             found;
    logic [1:0]       grant;
    logic [1:0]       cand;
    logic [WIDTH-1:0] sel_data;

    // ptr_valid_q keeps the lock off until a real grant exists, so inp1 wins first after reset.
    assign lock = ptr_valid_q && (burst_cnt_q < BURST_M1) && req[ptr_q];
    assign cap  = rst_n && (|req) && ((state_q == EMPTY) || out_ready);

    always_comb begin
        grant = ptr_q + 2'd1;
        found = 1'b0;
        cand  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        if (lock) begin
            grant = ptr_q;
        end
    end

    always_comb begin
        burst_cnt_d = 4'd0;
        if (ptr_valid_q && (grant == ptr_q)) begin
            burst_cnt_d = (burst_cnt_q < BURST_M1) ? burst_cnt_q + 4'd1 : burst_cnt_q;
        end
    end

    assign ack = cap ? (4'b0001 << grant) : 4'b0000;

    mux4way16 #(.WIDTH(WIDTH)) u_mux (
        .a    (inp1),
        .b    (inp2),
        .c    (inp3),
        .d    (inp4),
        .line (grant),
        .out  (sel_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            ptr_q       <= 2'b11;
            ptr_valid_q <= 1'b0;
            burst_cnt_q <= 4'd0;
            out_q       <= '0;
            line_q      <= 2'b00;
        end else if (cap) begin
            state_q     <= FULL;
            ptr_q       <= grant;
            ptr_valid_q <= 1'b1;
            burst_cnt_q <= burst_cnt_d;
            out_q       <= sel_data;
            line_q      <= grant;
        end else if (out_ready) begin
            state_q     <= EMPTY;
        end
    end

    assign out       = out_q;
    assign line      = line_q;
    assign out_valid = (state_q == FULL);
endmodule
